// File: rtl/mem_access_stage.sv
// RV64 memory-access stage: lane-aligns loads and stores, flags faults,
// and backpressures EX while a data-memory transaction is in flight.
module mem_access_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      wb_rd_in,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_exc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [4:0]      r_rd;
    logic            r_rw;

    logic            w_mem;
    logic            w_acc;
    logic            w_mis;
    logic            w_ill;
    logic            w_fault;
    logic [2:0]      w_amask;
    logic [7:0]      w_bmask;
    logic [XLEN-1:0] w_smask;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_wstrb;
    logic [XLEN-1:0] w_ldsh;
    logic [XLEN-1:0] w_ldext;

    assign in_ready = (r_state == S_IDLE) && (!wb_valid || wb_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_mem    = mem_read_in || mem_write_in;

    always_comb begin
        w_amask = 3'b000;
        w_bmask = 8'h01;
        unique case (funct3_in[1:0])
            2'd0: begin w_amask = 3'b000; w_bmask = 8'h01; end
            2'd1: begin w_amask = 3'b001; w_bmask = 8'h03; end
            2'd2: begin w_amask = 3'b011; w_bmask = 8'h0F; end
            default: begin w_amask = 3'b111; w_bmask = 8'hFF; end
        endcase
    end

    always_comb begin
        w_smask = '0;
        for (int i = 0; i < 8; i++) begin
            w_smask[8*i +: 8] = {8{w_bmask[i]}};
        end
    end

    assign w_mis   = |(alu_result_in[2:0] & w_amask);
    assign w_ill   = (mem_read_in && funct3_in == 3'b111)
                  || (mem_write_in && funct3_in[2])
                  || (mem_read_in && mem_write_in);
    assign w_fault = w_mem && (w_mis || w_ill);
    assign w_wdata = (store_data_in & w_smask) << {alu_result_in[2:0], 3'b000};
    assign w_wstrb = w_bmask << alu_result_in[2:0];

    // Address and size are registered, so extraction uses the held copies.
    assign w_ldsh = dmem_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_ldext = w_ldsh;
        unique case (r_size)
            2'd0: w_ldext = r_uns ? {56'b0, w_ldsh[7:0]}
                                  : {{56{w_ldsh[7]}}, w_ldsh[7:0]};
            2'd1: w_ldext = r_uns ? {48'b0, w_ldsh[15:0]}
                                  : {{48{w_ldsh[15]}}, w_ldsh[15:0]};
            2'd2: w_ldext = r_uns ? {32'b0, w_ldsh[31:0]}
                                  : {{32{w_ldsh[31]}}, w_ldsh[31:0]};
            default: w_ldext = w_ldsh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_size         <= '0;
            r_uns          <= 1'b0;
            r_rd           <= '0;
            r_rw           <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= '0;
            dmem_we        <= 1'b0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            misalign_exc   <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_addr <= alu_result_in;
                        r_size <= funct3_in[1:0];
                        r_uns  <= funct3_in[2];
                        r_rd   <= wb_rd_in;
                        r_rw   <= reg_write_in;
                        if (!w_mem) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= reg_write_in;
                            wb_rd        <= wb_rd_in;
                            wb_data      <= alu_result_in;
                        end else if (w_fault) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= 1'b0;
                            wb_rd        <= wb_rd_in;
                            wb_data      <= alu_result_in;
                            misalign_exc <= 1'b1;
                        end else begin
                            r_state        <= S_REQ;
                            dmem_req_valid <= 1'b1;
                            dmem_addr      <= {alu_result_in[XLEN-1:3], 3'b000};
                            dmem_we        <= mem_write_in;
                            dmem_wdata     <= mem_write_in ? w_wdata : '0;
                            dmem_wstrb     <= mem_write_in ? w_wstrb : 8'h00;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (dmem_we) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= 1'b0;
                            wb_rd        <= r_rd;
                            wb_data      <= r_addr;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (dmem_resp_valid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= r_rw;
                        wb_rd        <= r_rd;
                        wb_data      <= w_ldext;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
